// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match sequencer.
package pong_pkg;

  localparam int SCORE_W       = 4;
  localparam int FRAME_CNT_W   = 8;
  localparam int PADDLE_HOME_Y = 192;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

endpackage

// File: rtl/frame_counter.sv
// Saturating frame-tick counter shared by the SERVE and POINT waits.
module frame_counter
  import pong_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   tick,
  input  logic [FRAME_CNT_W-1:0] limit,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] count_q, count_d;

  // clear wins over tick so a tick coinciding with a state change is dropped
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q >= limit);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: serve, rally, point hold and game-over handling for pong.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int POINT_FRAMES = 60,
  parameter int AUTO_SERVE   = 180
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               launch,
  input  logic               pause,
  input  logic               left_miss,
  input  logic               right_miss,
  output logic [2:0]         state,
  output logic               ball_reset,
  output logic               motion_en,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0]     WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] POINT_LIM = FRAME_CNT_W'(POINT_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] SERVE_LIM = FRAME_CNT_W'(AUTO_SERVE);
  localparam logic                   AUTO_EN   = (AUTO_SERVE != 0);

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic                 side_q, side_d;
  logic                 winner_q, winner_d;
  logic                 motion_q, motion_d;
  logic                 launch_q;
  logic                 launch_rise;
  logic                 cnt_clear;
  logic                 cnt_done;
  logic [FRAME_CNT_W-1:0] cnt_limit;

  assign launch_rise = launch & ~launch_q;
  assign cnt_clear   = (state_d != state_q);
  assign cnt_limit   = (state_q == ST_SERVE) ? SERVE_LIM : POINT_LIM;

  frame_counter u_frame_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .tick    (frame_tick),
    .limit   (cnt_limit),
    .done    (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    side_d   = side_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_rise) begin
          state_d = ST_SERVE;
          p1_d    = '0;
          p2_d    = '0;
          side_d  = 1'b0;
        end
      end
      ST_SERVE: begin
        if (launch_rise || (AUTO_EN && cnt_done)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // a simultaneous double miss is a replay: no score, serve side kept
        if (left_miss || right_miss) begin
          state_d = ST_POINT;
          if (right_miss && !left_miss) begin
            side_d = 1'b1;
            if (p1_q < WIN) p1_d = p1_q + 1'b1;
          end
          if (left_miss && !right_miss) begin
            side_d = 1'b0;
            if (p2_q < WIN) p2_d = p2_q + 1'b1;
          end
        end
      end
      ST_POINT: begin
        if (cnt_done) begin
          if ((p1_q == WIN) || (p2_q == WIN)) begin
            state_d  = ST_GAME_OVER;
            winner_d = (p2_q == WIN);
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      ST_GAME_OVER: begin
        if (launch_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    motion_d = (state_d == ST_PLAY) && !pause;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      side_q   <= 1'b0;
      winner_q <= 1'b0;
      motion_q <= 1'b0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      side_q   <= side_d;
      winner_q <= winner_d;
      motion_q <= motion_d;
      launch_q <= launch;
    end
  end

  assign state      = state_q;
  assign ball_reset = (state_q != ST_PLAY);
  assign motion_en  = motion_q;
  assign serve_side = side_q;
  assign score_p1   = p1_q;
  assign score_p2   = p2_q;
  assign game_over  = (state_q == ST_GAME_OVER);
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed scenarios plus random play against a match-rules model.
module tb_pong_match_ctrl;

  localparam int WIN = 7;
  localparam int PF  = 60;
  localparam int AS  = 3;

  logic       clk = 1'b0;
  logic       reset_n, frame_tick, launch, pause, left_miss, right_miss;
  logic [2:0] state;
  logic       ball_reset, motion_en, serve_side, game_over, winner;
  logic [3:0] score_p1, score_p2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pong_match_ctrl #(.WIN_SCORE(WIN), .POINT_FRAMES(PF), .AUTO_SERVE(AS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .launch     (launch),
    .pause      (pause),
    .left_miss  (left_miss),
    .right_miss (right_miss),
    .state      (state),
    .ball_reset (ball_reset),
    .motion_en  (motion_en),
    .serve_side (serve_side),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over),
    .winner     (winner)
  );

  // Match-rules model: phase 0 idle, 1 serve, 2 rally, 3 point hold, 4 game over
  typedef struct {
    int ph; int p1; int p2; int side; int cnt; int win; int mot; int lq;
  } model_t;

  model_t m;

  function automatic model_t reset_model();
    model_t r;
    r.ph = 0; r.p1 = 0; r.p2 = 0; r.side = 0; r.cnt = 0; r.win = 0; r.mot = 0; r.lq = 0;
    return r;
  endfunction

  function automatic model_t next_model(model_t c, logic ft, logic l, logic p, logic lm, logic rm);
    model_t n;
    bit press;
    n = c;
    press = l && (c.lq == 0);
    if (c.ph == 0 && press) begin
      n.ph = 1; n.p1 = 0; n.p2 = 0; n.side = 0;
    end else if (c.ph == 1 && (press || (AS != 0 && c.cnt >= AS))) begin
      n.ph = 2;
    end else if (c.ph == 2 && (lm || rm)) begin
      n.ph = 3;
      if (rm && !lm) begin n.p1 = (c.p1 < WIN) ? c.p1 + 1 : c.p1; n.side = 1; end
      if (lm && !rm) begin n.p2 = (c.p2 < WIN) ? c.p2 + 1 : c.p2; n.side = 0; end
    end else if (c.ph == 3 && c.cnt >= PF) begin
      if (c.p1 == WIN || c.p2 == WIN) begin
        n.ph = 4; n.win = (c.p2 == WIN) ? 1 : 0;
      end else begin
        n.ph = 1;
      end
    end else if (c.ph == 4 && press) begin
      n.ph = 0;
    end
    if (n.ph != c.ph) n.cnt = 0;
    else if (ft) n.cnt = (c.cnt < 255) ? c.cnt + 1 : 255;
    n.mot = (n.ph == 2 && !p) ? 1 : 0;
    n.lq  = l ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= reset_model();
    else m <= next_model(m, frame_tick, launch, pause, left_miss, right_miss);
  end

  function automatic logic [15:0] exp_vec();
    return {3'(m.ph), 4'(m.p1), 4'(m.p2), 1'(m.side), 1'(m.ph != 2), 1'(m.mot),
            1'(m.ph == 4), 1'(m.win)};
  endfunction

  function automatic logic [15:0] act_vec();
    return {state, score_p1, score_p2, serve_side, ball_reset, motion_en, game_over, winner};
  endfunction

  task automatic step(input logic ft, input logic l, input logic p, input logic lm, input logic rm);
    @(negedge clk);
    frame_tick = ft; launch = l; pause = p; left_miss = lm; right_miss = rm;
    @(posedge clk);
    #1;
  endtask

  // From SERVE: launch, miss (held two cycles), then sit out the point hold
  task automatic play_point(input logic lm, input logic rm);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, lm, rm);
    step(0, 0, 0, lm, rm);
    step(0, 0, 0, 0, 0);
    repeat (PF) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; frame_tick = 0; launch = 0; pause = 0; left_miss = 0; right_miss = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (act_vec() !== 16'b000_0000_0000_0_1_0_0_0)
      $display("FAIL reset_values: got %b want %b", act_vec(), 16'b000_0000_0000_0_1_0_0_0);
    else pass_cnt++;
    total_cnt++;
    if (act_vec() !== exp_vec()) $display("FAIL reset_model: got %b want %b", act_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_launch_once();
    int trans;
    logic [2:0] prev;
    trans = 0;
    prev = state;
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0, 0, 0);
      if (state !== prev) trans++;
      prev = state;
    end
    total_cnt++;
    if (trans != 1 || state !== 3'd1) $display("FAIL launch_held: transitions %0d state %0d want 1 and 1", trans, state);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd2 || motion_en !== 1'b1 || ball_reset !== 1'b0)
      $display("FAIL second_press: state %0d motion %b ball_reset %b want 2 1 0", state, motion_en, ball_reset);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_right_miss();
    step(0, 0, 0, 0, 1);
    total_cnt++;
    if (state !== 3'd3 || score_p1 !== 4'd1 || score_p2 !== 4'd0 || serve_side !== 1'b1)
      $display("FAIL right_miss: state %0d p1 %0d p2 %0d side %b want 3 1 0 1", state, score_p1, score_p2, serve_side);
    else pass_cnt++;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    repeat (PF) step(1, 0, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd3 || score_p1 !== 4'd1)
      $display("FAIL point_hold_edge: state %0d p1 %0d want 3 1", state, score_p1);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL point_to_serve: state %0d want 1", state);
    else pass_cnt++;
  endtask

  task automatic test_both_miss();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    total_cnt++;
    if (state !== 3'd3 || score_p1 !== 4'd1 || score_p2 !== 4'd0 || serve_side !== 1'b1)
      $display("FAIL both_miss: state %0d p1 %0d p2 %0d side %b want 3 1 0 1", state, score_p1, score_p2, serve_side);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
    repeat (PF) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    total_cnt++;
    if (act_vec() !== exp_vec()) $display("FAIL both_miss_model: got %b want %b", act_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_auto_serve_pause();
    repeat (AS) step(1, 0, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL auto_serve_early: state %0d want 1", state);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd2) $display("FAIL auto_serve: state %0d want 2", state);
    else pass_cnt++;
    step(0, 0, 1, 0, 0);
    total_cnt++;
    if (motion_en !== 1'b0 || state !== 3'd2) $display("FAIL pause_motion: motion %b state %0d want 0 2", motion_en, state);
    else pass_cnt++;
    step(0, 0, 1, 0, 1);
    total_cnt++;
    if (score_p1 !== 4'd2 || state !== 3'd3) $display("FAIL paused_miss: p1 %0d state %0d want 2 3", score_p1, state);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
    repeat (PF) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_game_over();
    repeat (6) play_point(1, 0);
    total_cnt++;
    if (score_p2 !== 4'd6 || state !== 3'd1) $display("FAIL p2_six: p2 %0d state %0d want 6 1", score_p2, state);
    else pass_cnt++;
    play_point(1, 0);
    total_cnt++;
    if (state !== 3'd4 || game_over !== 1'b1 || winner !== 1'b1 || score_p2 !== 4'd7)
      $display("FAIL game_over: state %0d go %b winner %b p2 %0d want 4 1 1 7", state, game_over, winner, score_p2);
    else pass_cnt++;
    step(0, 0, 0, 1, 1);
    total_cnt++;
    if (state !== 3'd4 || score_p2 !== 4'd7 || score_p1 !== 4'd2)
      $display("FAIL game_over_frozen: state %0d p1 %0d p2 %0d want 4 2 7", state, score_p1, score_p2);
    else pass_cnt++;
    step(0, 1, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd0 || game_over !== 1'b0) $display("FAIL game_over_exit: state %0d go %b want 0 0", state, game_over);
    else pass_cnt++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_play();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (3) play_point(0, 1);
    repeat (2) play_point(1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    total_cnt++;
    if (state !== 3'd2 || score_p1 !== 4'd3 || score_p2 !== 4'd2)
      $display("FAIL pre_reset: state %0d p1 %0d p2 %0d want 2 3 2", state, score_p1, score_p2);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (state !== 3'd0 || score_p1 !== 4'd0 || score_p2 !== 4'd0 || ball_reset !== 1'b1 || motion_en !== 1'b0)
      $display("FAIL async_reset: state %0d p1 %0d p2 %0d br %b me %b want 0 0 0 1 0",
               state, score_p1, score_p2, ball_reset, motion_en);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int bad;
    logic l, p;
    bad = 0;
    l = 1'b0;
    p = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) l = ~l;
      if ($urandom_range(0, 15) == 0) p = ~p;
      step($urandom_range(0, 1) == 1, l, p, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
      total_cnt++;
      if (act_vec() !== exp_vec()) begin
        if (bad < 10) $display("FAIL random_cycle_%0d: got %b want %b", i, act_vec(), exp_vec());
        bad++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_launch_once();
    test_right_miss();
    test_both_miss();
    test_auto_serve_pause();
    test_game_over();
    test_reset_mid_play();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
